// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU (add, sub, and, xor).
//
// Stage 1 registers the operands, the effective B operand (inverted for
// sub), the carry-in, per-bit generate/propagate and 4-bit group G/P.
// Stage 2 resolves carries with a two-level lookahead tree (4-bit groups
// inside 16-bit blocks, blocks rippling into each other), forms the sum,
// selects the result and registers it together with the condition codes.
//
// Optional feature macro: ALU_FLAGS_EN
//   defined     -> carry/zero/sign/overflow flags are computed and registered
//   not defined -> out_cf/out_zf/out_sf/out_of are tied to 0, no flag flops
//
// Parameters:
//   WIDTH      operand width, multiple of 16 in 16..64
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand bundle handshake
//   in_op                 00 add, 01 sub, 10 and, 11 xor
//   in_a, in_b            operands
//   out_valid/out_ready   result bundle handshake
//   out_result            result
//   out_cf/zf/sf/of       carry(borrow)/zero/sign/overflow flags
//
// Handshake: a bundle moves across an interface at a rising edge where
// valid and ready are both 1. Valid never depends on ready; in_ready is a
// pure function of pipeline occupancy and out_ready (never of in_valid);
// a presented result holds stable while out_valid & ~out_ready.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cf,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of
);

  localparam int NG = WIDTH / 4;   // number of 4-bit groups
  localparam int NB = WIDTH / 16;  // number of 16-bit blocks

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // 4-bit lookahead unit: carries into positions 0..3 from G/P and carry-in.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       cin);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // 4-bit lookahead unit: combined {generate, propagate} of four positions.
  function automatic logic [1:0] cla4_gp(input logic [3:0] g,
                                         input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  // ---------------------------------------------------------------- control
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv;
  logic in_fire;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_adv;
  assign in_fire  = in_valid & in_ready;

  // ---------------------------------------------------------------- stage 1
  logic [1:0]       s1_op_q,  s1_op_d;
  logic [WIDTH-1:0] s1_a_q,   s1_a_d;
  logic [WIDTH-1:0] s1_b_q,   s1_b_d;
  logic             s1_cin_q, s1_cin_d;
  logic [WIDTH-1:0] s1_g_q,   s1_g_d;
  logic [WIDTH-1:0] s1_p_q,   s1_p_d;
  logic [NG-1:0]    s1_gg_q,  s1_gg_d;
  logic [NG-1:0]    s1_gp_q,  s1_gp_d;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [1:0]       grp_gp_w;

  always_comb begin : s1_gp_calc
    // Subtraction is A + ~B + 1.
    b_eff = (in_op == OP_SUB) ? ~in_b : in_b;
    g_bit = in_a & b_eff;
    p_bit = in_a ^ b_eff;
    grp_g = '0;
    grp_p = '0;
    grp_gp_w = '0;
    for (int k = 0; k < NG; k++) begin
      grp_gp_w = cla4_gp(g_bit[k*4 +: 4], p_bit[k*4 +: 4]);
      grp_g[k] = grp_gp_w[1];
      grp_p[k] = grp_gp_w[0];
    end
  end

  always_comb begin : s1_next
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s1_g_d     = s1_g_q;
    s1_p_d     = s1_p_q;
    s1_gg_d    = s1_gg_q;
    s1_gp_d    = s1_gp_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_b_d     = b_eff;
      s1_cin_d   = (in_op == OP_SUB);
      s1_g_d     = g_bit;
      s1_p_d     = p_bit;
      s1_gg_d    = grp_g;
      s1_gp_d    = grp_p;
    end else if (s2_adv) begin
      // Contents moved on (or were empty) and nothing new arrived.
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_gg_q    <= '0;
      s1_gp_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s1_g_q     <= s1_g_d;
      s1_p_q     <= s1_p_d;
      s1_gg_q    <= s1_gg_d;
      s1_gp_q    <= s1_gp_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [WIDTH-1:0] carry;    // carry into each bit position
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] res_w;
  logic [3:0]       grp_c;    // carries into the four groups of a block
  logic [1:0]       blk_gp;
  logic             c_blk;    // carry into the current block; carry out after the loop

  always_comb begin : s2_carry_tree
    carry  = '0;
    grp_c  = '0;
    blk_gp = '0;
    c_blk  = s1_cin_q;
    for (int blk = 0; blk < NB; blk++) begin
      grp_c  = cla4_carries(s1_gg_q[blk*4 +: 4], s1_gp_q[blk*4 +: 4], c_blk);
      blk_gp = cla4_gp(s1_gg_q[blk*4 +: 4], s1_gp_q[blk*4 +: 4]);
      for (int j = 0; j < 4; j++) begin
        carry[(blk*4 + j)*4 +: 4] = cla4_carries(s1_g_q[(blk*4 + j)*4 +: 4],
                                                 s1_p_q[(blk*4 + j)*4 +: 4],
                                                 grp_c[j]);
      end
      // Blocks ripple: carry out of this block feeds the next one.
      c_blk = blk_gp[1] | (blk_gp[0] & c_blk);
    end
    sum_w = s1_p_q ^ carry;
    case (s1_op_q)
      OP_ADD, OP_SUB: res_w = sum_w;
      OP_AND:         res_w = s1_a_q & s1_b_q;
      OP_XOR:         res_w = s1_p_q;
      default:        res_w = sum_w;
    endcase
  end

  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_load;

  assign s2_load = s1_valid_q & s2_adv;

  always_comb begin : s2_next
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      s2_result_d = res_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;

`ifdef ALU_FLAGS_EN
  logic s2_cf_q, s2_cf_d;
  logic s2_zf_q, s2_zf_d;
  logic s2_sf_q, s2_sf_d;
  logic s2_of_q, s2_of_d;
  logic is_arith;

  always_comb begin : s2_flags_next
    is_arith = ~s1_op_q[1];
    s2_cf_d  = s2_cf_q;
    s2_zf_d  = s2_zf_q;
    s2_sf_d  = s2_sf_q;
    s2_of_d  = s2_of_q;
    if (s2_load) begin
      // Sub reports borrow, which is the inverted carry out of A + ~B + 1.
      s2_cf_d = is_arith & ((s1_op_q == OP_SUB) ? ~c_blk : c_blk);
      s2_zf_d = (res_w == '0);
      s2_sf_d = res_w[WIDTH-1];
      // With B already inverted for sub, one overflow rule covers both ops.
      s2_of_d = is_arith & (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &
                (sum_w[WIDTH-1] != s1_a_q[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_cf_q <= 1'b0;
      s2_zf_q <= 1'b0;
      s2_sf_q <= 1'b0;
      s2_of_q <= 1'b0;
    end else begin
      s2_cf_q <= s2_cf_d;
      s2_zf_q <= s2_zf_d;
      s2_sf_q <= s2_sf_d;
      s2_of_q <= s2_of_d;
    end
  end

  assign out_cf = s2_cf_q;
  assign out_zf = s2_zf_q;
  assign out_sf = s2_sf_q;
  assign out_of = s2_of_q;
`else
  assign out_cf = 1'b0;
  assign out_zf = 1'b0;
  assign out_sf = 1'b0;
  assign out_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe (WIDTH = 32).
// Expected flags are masked to zero when ALU_FLAGS_EN is not defined.
module tb_alu_pipe;

`ifdef ALU_FLAGS_EN
  localparam logic FLG = 1'b1;
`else
  localparam logic FLG = 1'b0;
`endif

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // ---------------------------------------------------------- clock / reset
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_cf, out_zf, out_sf, out_of;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_cf     (out_cf),
    .out_zf     (out_zf),
    .out_sf     (out_sf),
    .out_of     (out_of)
  );

  // ---------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic       pat_en = 1'b0;
  logic [7:0] pat    = 8'b1011_0110;
  logic       sb_en  = 1'b0;
  logic [35:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;  // {cf, zf, sf, of}
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pat_en) out_ready = pat[cyc % 8];
    #1;
  endtask

  task automatic set_in(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    #1;
  endtask

  task automatic push_exp(input logic [31:0] res, input logic [3:0] flags);
    exp_q.push_back({res, flags & {4{FLG}}});
  endtask

  // Presents one bundle and waits (bounded) until it is accepted.
  task automatic send(input vec_t v);
    int guard;
    set_in(v.op, v.a, v.b);
    guard = 0;
    while (!in_ready && guard < 30) begin
      tick();
      guard++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      push_exp(v.res, v.flags);
      tick();
    end
  endtask

  // ---------------------------------------------------------- scoreboard
  always @(negedge clk) begin
    if (sb_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected none", out_result);
      end else begin
        check("sb_result", {28'd0, out_result, out_cf, out_zf, out_sf, out_of},
              {28'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------------------------------------------------- test
  initial begin
    vecs[0]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0011};
    vecs[1]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100};
    vecs[2]  = '{OP_SUB, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b1010};
    vecs[3]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1100};
    vecs[4]  = '{OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 4'b0000};
    vecs[5]  = '{OP_AND, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030, 4'b0000};
    vecs[6]  = '{OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 4'b0000};
    vecs[7]  = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1010};
    vecs[8]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001};
    vecs[9]  = '{OP_ADD, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 4'b0010};
    vecs[10] = '{OP_XOR, 32'h5555_AAAA, 32'h5555_AAAA, 32'h0000_0000, 4'b0100};
    vecs[11] = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1101};

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(out_result), 64'd0);
    check("rst_flags", 64'({out_cf, out_zf, out_sf, out_of}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table: each vector alone, checking two-cycle latency and values
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].op, vecs[i].a, vecs[i].b);
      check("vec_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d_early", i), 64'(out_valid), 64'd0);
      tick();
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].res));
      check($sformatf("vec%0d_flags", i), 64'({out_cf, out_zf, out_sf, out_of}),
            64'(vecs[i].flags & {4{FLG}}));
      tick();
      check($sformatf("vec%0d_drained", i), 64'(out_valid), 64'd0);
    end

    // Backpressure: four back-to-back adds with the consumer stalled
    sb_en     = 1'b1;
    out_ready = 1'b0;
    #1;
    set_in(OP_ADD, 32'd1, 32'd2);
    check("bp_acc0", 64'(in_ready), 64'd1);
    push_exp(32'd3, 4'b0000);
    tick();
    set_in(OP_ADD, 32'd10, 32'd20);
    check("bp_acc1", 64'(in_ready), 64'd1);
    push_exp(32'd30, 4'b0000);
    tick();
    set_in(OP_ADD, 32'h0000_FFFF, 32'd1);
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_full_valid", 64'(out_valid), 64'd1);
    tick();
    check("bp_full_ready2", 64'(in_ready), 64'd0);
    check("bp_stall_hold", 64'(out_result), 64'd3);
    out_ready = 1'b1;
    #1;
    check("bp_drain_ready", 64'(in_ready), 64'd1);
    push_exp(32'h0001_0000, 4'b0000);
    tick();
    check("bp_nobubble0", 64'(out_valid), 64'd1);
    set_in(OP_ADD, 32'hFFFF_FFFF, 32'd2);
    check("bp_acc3", 64'(in_ready), 64'd1);
    push_exp(32'd1, 4'b1000);
    tick();
    in_valid = 1'b0;
    check("bp_nobubble1", 64'(out_valid), 64'd1);
    tick();
    check("bp_nobubble2", 64'(out_valid), 64'd1);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);
    check("bp_sb_drained", 64'(exp_q.size()), 64'd0);

    // Streaming all vectors with a toggling consumer
    pat_en = 1'b1;
    for (int i = 0; i < 12; i++) send(vecs[i]);
    in_valid = 1'b0;
    pat_en   = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("stream_sb_drained", 64'(exp_q.size()), 64'd0);

    // Reset with both stages full
    sb_en     = 1'b0;
    out_ready = 1'b0;
    set_in(OP_ADD, 32'd7, 32'd8);
    tick();
    set_in(OP_SUB, 32'd9, 32'd4);
    tick();
    in_valid = 1'b0;
    check("mid_full_valid", 64'(out_valid), 64'd1);
    check("mid_full_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_no_stale", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Two-stage pipelined integer ALU for the execute stage. Stage 1 turns operands into per-bit generate/propagate signals and 4-bit group G/P. Stage 2 resolves carries through the two-level lookahead tree (4-bit groups, then 16-bit blocks, both using the existing 4-bit lookahead unit), forms the sum, logic result and condition codes, and presents them to writeback/CC logic over a valid/ready handshake.

## Interface
Parameters:
- `WIDTH`, 32: operand width; must be a multiple of 16, legal range 16–64.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operand bundle valid.
- `in_ready`, out, 1: stage 1 can accept a bundle this cycle.
- `in_op`, in, 2: 00 add, 01 sub, 10 and, 11 xor.
- `in_a`, in, WIDTH: operand A.
- `in_b`, in, WIDTH: operand B.
- `out_valid`, out, 1: result bundle valid.
- `out_ready`, in, 1: consumer accepts the result this cycle.
- `out_result`, out, WIDTH: result.
- `out_cf`, `out_zf`, `out_sf`, `out_of`, out, 1 each: carry/borrow, zero, sign, overflow.

## Operation
- Transfer in: `in_valid & in_ready` at a rising edge.
- Transfer out: `out_valid & out_ready` at a rising edge.
- Stage 1 registers: `s1_valid`, op, A, effective B, cin, per-bit G/P, 4-bit group G/P.
  - sub: effective B = ~in_b, cin = 1.
  - all other ops: effective B = in_b, cin = 0.
- Stage 2 (`s2_valid`, result, flags) computes:
  - group carries from group G/P plus block G/P (16-bit);
  - carries between 16-bit blocks ripple;
  - sum = P ^ carries.
- Results:
  - add: A+B mod 2^WIDTH.
  - sub: A−B mod 2^WIDTH.
  - and: A&B.
  - xor: A^B.
- Flags:
  - add: CF = carry out; OF = (A[msb]==B[msb]) & (sum[msb]!=A[msb]).
  - sub: CF = ~carry out (borrow, 1 when A<B unsigned); OF = (A[msb]!=B[msb]) & (res[msb]!=A[msb]).
  - and/xor: CF = OF = 0.
  - all ops: ZF = (result==0); SF = result[msb].
- Flow control:
  - `s2_adv = ~s2_valid | out_ready`.
  - `in_ready = ~s1_valid | s2_adv`, purely combinational, no dependence on `in_valid`.
  - Stage 1 loads on input transfer. If stage 1 advances without a new transfer, `s1_valid` clears.
  - Stage 2 loads from stage 1 when `s1_valid & s2_adv`. If it advances with `s1_valid` = 0, `s2_valid` clears.
- Ordering: strictly in order; no bundle is dropped or duplicated.
- Stalled outputs hold stable while `out_valid & ~out_ready`.

## Timing
- Reset (async assert, sync deassert externally):
  - `s1_valid`, `s2_valid` = 0; all data and flag registers = 0.
  - Hence `out_valid` = 0, `out_result` = 0, all flags = 0, `in_ready` = 1.
- Latency: a bundle accepted at edge N appears with `out_valid` = 1 after edge N+1 and can be consumed at edge N+2.
- Throughput: one bundle per cycle while `out_ready` = 1.
- Full: both stages valid and `out_ready` = 0 ⇒ `in_ready` = 0 in the same cycle.
- Full, then `out_ready` = 1: stage 2 drains and stage 1 moves up at the same edge; a new input is accepted at that edge.
- Simultaneous in/out transfer when full: legal, occupancy unchanged.
- Reset mid-operation: in-flight bundles are discarded; no partial result is ever presented.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry out is visible only through CF.

## Configuration
- `ALU_FLAGS_EN` defined: flag logic and flag registers are built as specified above.
- Not defined: `out_cf`, `out_zf`, `out_sf`, `out_of` are tied to 0 and no flag registers exist. Result, latency and handshake are unchanged.

## Test plan
- add 0x7FFFFFFF + 0x00000001 → 0x80000000, OF = 1, SF = 1, CF = 0, ZF = 0, visible 2 cycles after acceptance.
- sub 5 − 5 → 0, ZF = 1, CF = 0. Sub 3 − 5 → 0xFFFFFFFE, CF = 1, SF = 1, OF = 0.
- add 0xFFFFFFFF + 1 → 0, CF = 1, ZF = 1 (full carry chain across both 16-bit blocks). xor 0xF0F0F0F0 ^ 0xFFFFFFFF → 0x0F0F0F0F, CF = OF = 0.
- Backpressure: issue 4 back-to-back adds with `out_ready` = 0 → exactly 2 accepted, `in_ready` = 0 from the third cycle. Raise `out_ready` → results emerge in order, the remaining 2 are accepted, with no bubble while `out_ready` stays 1.
- Reset: assert `rst_n` = 0 with both stages valid → `out_valid` = 0 and `in_ready` = 1 immediately. After release, no stale result appears.
- Build without `ALU_FLAGS_EN`: repeat the first test → result 0x80000000, all flags 0.
